// File: rtl/des_dec_iter.sv
// Iterative DES decryption engine: one Feistel round per clock, 16 rounds per block.
// Subkeys are produced on the fly by right-rotating C/D, so K16 comes first and K1 last.
module des_dec_iter #(
    parameter logic [64:1] RESET_OUT = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [64:1] in_data,
    input  logic [64:1] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [64:1] out_data
);

    localparam int unsigned IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9,  1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int unsigned FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9,  49, 17, 57, 25};
    localparam int unsigned E_T [48] = '{
        32, 1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9,  10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    localparam int unsigned P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1,  15, 23, 26, 5,  18, 31, 10,
        2,  8, 24, 14, 32, 27, 3,  9,  19, 13, 30, 6,  22, 11, 4,  25};
    localparam int unsigned PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
        10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
        14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4};
    localparam int unsigned PC2_T [48] = '{
        14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10, 23, 19, 12, 4,
        26, 8,  16, 7,  27, 20, 13, 2,  41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    // Flattened S-boxes: entry index is {box, row, col}.
    localparam logic [3:0] SBOX_T [512] = '{
        14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7, 0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0, 15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
        15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10, 3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15, 13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
        10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7, 1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
        7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15, 13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4, 3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
        2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9, 14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14, 11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
        12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11, 10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6, 4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
        4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1, 13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2, 6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
        13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7, 1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8, 2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

    function automatic logic [64:1] f_ip(input logic [64:1] x);
        logic [64:1] y;
        for (int i = 0; i < 64; i++) y[64 - i] = x[65 - IP_T[i]];
        return y;
    endfunction

    function automatic logic [64:1] f_fp(input logic [64:1] x);
        logic [64:1] y;
        for (int i = 0; i < 64; i++) y[64 - i] = x[65 - FP_T[i]];
        return y;
    endfunction

    function automatic logic [56:1] f_pc1(input logic [64:1] x);
        logic [56:1] y;
        for (int i = 0; i < 56; i++) y[56 - i] = x[65 - PC1_T[i]];
        return y;
    endfunction

    function automatic logic [48:1] f_pc2(input logic [56:1] x);
        logic [48:1] y;
        for (int i = 0; i < 48; i++) y[48 - i] = x[57 - PC2_T[i]];
        return y;
    endfunction

    function automatic logic [32:1] f_feistel(input logic [32:1] r, input logic [48:1] k);
        logic [48:1] x;
        logic [32:1] s;
        logic [32:1] y;
        logic [6:1]  six;
        logic [8:0]  idx;
        for (int i = 0; i < 48; i++) x[48 - i] = r[33 - E_T[i]];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            six = x[48 - 6 * b -: 6];
            idx = {b[2:0], six[6], six[1], six[5:2]};
            s[32 - 4 * b -: 4] = SBOX_T[idx];
        end
        for (int i = 0; i < 32; i++) y[32 - i] = s[33 - P_T[i]];
        return y;
    endfunction

    typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

    state_e      state_q;
    logic [4:0]  rnd_q;
    logic [32:1] l_q, r_q;
    logic [28:1] c_q, d_q;

    logic [64:1] ip_blk;
    logic [56:1] pc1_key;
    logic [32:1] r_next;
    logic [28:1] c_rot, d_rot;
    logic        one_shift;

    assign in_ready  = rst_n && (state_q == StIdle);
    assign ip_blk    = f_ip(in_data);
    assign pc1_key   = f_pc1(in_key);
    assign r_next    = l_q ^ f_feistel(r_q, f_pc2({c_q, d_q}));
    // Rounds 1, 8 and 15 step back over the single-shift schedule positions 16, 9 and 2.
    assign one_shift = (rnd_q == 5'd1) || (rnd_q == 5'd8) || (rnd_q == 5'd15);
    assign c_rot     = one_shift ? {c_q[1], c_q[28:2]} : {c_q[2:1], c_q[28:3]};
    assign d_rot     = one_shift ? {d_q[1], d_q[28:2]} : {d_q[2:1], d_q[28:3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rnd_q     <= '0;
            l_q       <= '0;
            r_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            out_valid <= 1'b0;
            out_data  <= RESET_OUT;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        l_q     <= ip_blk[64:33];
                        r_q     <= ip_blk[32:1];
                        c_q     <= pc1_key[56:29];
                        d_q     <= pc1_key[28:1];
                        rnd_q   <= 5'd1;
                        state_q <= StRound;
                    end
                end
                StRound: begin
                    l_q <= r_q;
                    r_q <= r_next;
                    if (rnd_q == 5'd16) begin
                        out_data  <= f_fp({r_next, r_q});
                        out_valid <= 1'b1;
                        rnd_q     <= '0;
                        state_q   <= StDone;
                    end else begin
                        c_q   <= c_rot;
                        d_q   <= d_rot;
                        rnd_q <= rnd_q + 5'd1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_des_dec_iter.sv
// Bench for des_dec_iter: known answers, backpressure, streaming, reset and a random
// round trip through a behavioural DES model with a conventional precomputed key schedule.
module tb_des_dec_iter;

    localparam logic [64:1] RESET_OUT = 64'h0;
    localparam logic [63:0] KAT1_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] KAT1_CT  = 64'h85E813540F0AB405;
    localparam logic [63:0] KAT1_PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] KAT2_KEY = 64'h0E329232EA6D0D73;
    localparam logic [63:0] KAT2_CT  = 64'h0000000000000000;
    localparam logic [63:0] KAT2_PT  = 64'h8787878787878787;
    localparam logic [63:0] PAR_KEY  = 64'h123556789ABDDEF0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [64:1] in_data = '0;
    logic [64:1] in_key = '0;
    logic        in_ready;
    logic        out_valid;
    logic [64:1] out_data;

    int n_cmp = 0;
    int n_bad = 0;

    des_dec_iter #(.RESET_OUT(RESET_OUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Reference model tables (FIPS 46-3), 1-based bit numbers, MSB is bit 1.
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9,  1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9,  49, 17, 57, 25};
    localparam int E_T [48] = '{
        32, 1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9,  10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1,  15, 23, 26, 5,  18, 31, 10,
        2,  8, 24, 14, 32, 27, 3,  9,  19, 13, 30, 6,  22, 11, 4,  25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
        10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
        14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10, 23, 19, 12, 4,
        26, 8,  16, 7,  27, 20, 13, 2,  41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int S_T [512] = '{
        14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7, 0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0, 15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
        15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10, 3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15, 13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
        10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7, 1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
        7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15, 13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4, 3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
        2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9, 14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14, 11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
        12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11, 10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6, 4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
        4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1, 13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2, 6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
        13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7, 1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8, 2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

    function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] y;
        int v;
        for (int i = 0; i < 48; i++) x[47 - i] = r[32 - E_T[i]];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            v = int'(x[47 - 6 * b -: 6]);
            s[31 - 4 * b -: 4] = 4'(S_T[b * 64 + ((v >> 5) * 2 + (v & 1)) * 16 + ((v >> 1) & 15)]);
        end
        for (int i = 0; i < 32; i++) y[31 - i] = s[32 - P_T[i]];
        return y;
    endfunction

    // Full DES with all 16 subkeys computed up front by left rotation, applied forward or reversed.
    function automatic logic [63:0] m_des(input logic [63:0] blk, input logic [63:0] key,
                                          input bit decrypt);
        logic [47:0] ks [16];
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [63:0] x, y;
        logic [31:0] l, r, t;
        for (int i = 0; i < 56; i++) cd[55 - i] = key[64 - PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int n = 0; n < 16; n++) begin
            c = (c << SHIFT_T[n]) | (c >> (28 - SHIFT_T[n]));
            d = (d << SHIFT_T[n]) | (d >> (28 - SHIFT_T[n]));
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[n][47 - i] = cd[56 - PC2_T[i]];
        end
        for (int i = 0; i < 64; i++) x[63 - i] = blk[64 - IP_T[i]];
        l = x[63:32];
        r = x[31:0];
        for (int n = 0; n < 16; n++) begin
            t = r;
            r = l ^ m_f(r, ks[decrypt ? 15 - n : n]);
            l = t;
        end
        x = {r, l};
        for (int i = 0; i < 64; i++) y[63 - i] = x[64 - FP_T[i]];
        return y;
    endfunction

    // Drives a block and returns once the handshake edge has passed; inputs are then scrambled.
    task automatic start_block(input logic [63:0] ct, input logic [63:0] key);
        int n;
        in_valid = 1'b1;
        in_data  = ct;
        in_key   = key;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        in_key   = {$urandom, $urandom};
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic accept;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_cmp++;
        if (out_data !== RESET_OUT) begin
            n_bad++;
            $display("FAIL reset_out_data: got %h expected %h", out_data, RESET_OUT);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_known_answer;
        logic [63:0] cts [3] = '{KAT1_CT, KAT2_CT, KAT1_CT};
        logic [63:0] keys [3] = '{KAT1_KEY, KAT2_KEY, PAR_KEY};
        logic [63:0] pts [3] = '{KAT1_PT, KAT2_PT, KAT1_PT};
        int lat;
        for (int k = 0; k < 3; k++) begin
            start_block(cts[k], keys[k]);
            wait_out(lat);
            n_cmp++;
            if (lat !== 16) begin
                n_bad++;
                $display("FAIL kat%0d_latency: got %0d edges expected 16", k, lat);
            end
            n_cmp++;
            if (out_data !== pts[k]) begin
                n_bad++;
                $display("FAIL kat%0d_data: got %h expected %h", k, out_data, pts[k]);
            end
            accept();
            n_cmp++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL kat%0d_release: got in_ready=%b out_valid=%b expected 1/0",
                         k, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        start_block(KAT2_CT, KAT2_KEY);
        wait_out(lat);
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== KAT2_PT) begin
                n_bad++;
                $display("FAIL hold_cycle%0d: got v=%b rdy=%b data=%h expected 1/0/%h",
                         c, out_valid, in_ready, out_data, KAT2_PT);
            end
            @(negedge clk);
        end
        accept();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_release: got in_ready=%b out_valid=%b expected 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        int cnt;
        bit hs;
        in_valid = 1'b1;
        in_data  = KAT1_CT;
        in_key   = KAT1_KEY;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        in_data   = KAT2_CT;
        in_key    = KAT2_KEY;
        out_ready = 1'b1;
        wait_out(cnt);
        n_cmp++;
        if (out_data !== KAT1_PT) begin
            n_bad++;
            $display("FAIL b2b_first: got %h expected %h", out_data, KAT1_PT);
        end
        cnt = 0;
        do begin
            hs = in_valid && in_ready;
            @(negedge clk);
            cnt++;
            if (hs) begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom};
            end
        end while (!out_valid && cnt < 60);
        n_cmp++;
        if (cnt !== 18) begin
            n_bad++;
            $display("FAIL b2b_spacing: got %0d edges expected 18", cnt);
        end
        n_cmp++;
        if (out_data !== KAT2_PT) begin
            n_bad++;
            $display("FAIL b2b_second: got %h expected %h", out_data, KAT2_PT);
        end
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic test_reset_mid;
        int lat;
        bit seen;
        start_block(KAT1_CT, KAT1_KEY);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== RESET_OUT || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_async: got v=%b data=%h rdy=%b expected 0/%h/0",
                     out_valid, out_data, in_ready, RESET_OUT);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_no_partial: got out_valid seen=%b expected 0", seen);
        end
        start_block(KAT1_CT, KAT1_KEY);
        wait_out(lat);
        n_cmp++;
        if (lat !== 16 || out_data !== KAT1_PT) begin
            n_bad++;
            $display("FAIL midreset_fresh: got lat=%0d data=%h expected 16/%h",
                     lat, out_data, KAT1_PT);
        end
        accept();
    endtask

    task automatic test_round_trip;
        logic [63:0] pt;
        logic [63:0] key;
        logic [63:0] ct;
        int lat;
        for (int k = 0; k < 1000; k++) begin
            pt  = {$urandom, $urandom};
            key = {$urandom, $urandom};
            ct  = m_des(pt, key, 1'b0);
            start_block(ct, key);
            wait_out(lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            n_cmp++;
            if (lat !== 16 || out_data !== pt) begin
                n_bad++;
                $display("FAIL round_trip%0d: key=%h ct=%h got lat=%0d data=%h expected 16/%h",
                         k, key, ct, lat, out_data, pt);
            end
            accept();
        end
    endtask

    initial begin
        test_reset();
        test_known_answer();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_round_trip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
